laser_multi_transmitter: RTL and testbench

Parametrised multi-channel laser line transmitter for the LaserDrop link. It serialises one DATA_W-bit word per channel into a framed, bit-timed stream on a complementary laser pair, and supports any number of independent channels with a per-channel valid/ready handshake. All channels share one programmable bit-period generator running off a single system clock. It replaces the fixed two-channel, fixed-rate transmitter and sits between the host data source and the GPIO laser drivers.

---
 rtl/laser_multi_transmitter.sv | 264 ++++++++++++++++++++++++++
 tb/tb_laser_multi_transmitter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/laser_multi_transmitter.sv
// -----------------------------------------------------------------------------
// laser_multi_transmitter
//
// Multi-channel LaserDrop line transmitter. Each channel accepts one DATA_W-bit
// word through a valid/ready handshake and sends it as a framed stream
// (START, DATA MSB first, optional PARITY, STOP) on a complementary laser
// pair. All channels share one programmable bit-period tick generator.
//
// Optional feature macro: LASER_TX_PARITY_EN
//   defined   -> an even-parity bit (XOR of the word) is sent between DATA
//                and STOP
//   undefined -> DATA goes straight to STOP
//
// Parameters:
//   NUM_CH  number of independent channels (>= 1)
//   DATA_W  bits per word (>= 1)
//   DIV_W   width of the bit-period divider
//
// Ports:
//   clock       system clock
//   reset       asynchronous active-high reset
//   en          global enable; low aborts every frame and holds lasers off
//   divider     bit period in clock cycles (0 behaves as 1)
//   data_in     word for channel i at [i*DATA_W +: DATA_W]
//   data_valid  per-channel word valid
//   data_ready  per-channel ready (transfer on valid & ready at a clock edge)
//   laser_out   channel i pair at [2i+1:2i] = {bit, ~bit}, 2'b00 when idle
//   busy        channel i is mid-frame
//   done        one-cycle pulse when channel i completes its STOP bit
// -----------------------------------------------------------------------------
module laser_multi_transmitter #(
   parameter int NUM_CH = 2,
   parameter int DATA_W = 8,
   parameter int DIV_W  = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       en,
   input  logic [DIV_W-1:0]           divider,
   input  logic [NUM_CH*DATA_W-1:0]   data_in,
   input  logic [NUM_CH-1:0]          data_valid,
   output logic [NUM_CH-1:0]          data_ready,
   output logic [2*NUM_CH-1:0]        laser_out,
   output logic [NUM_CH-1:0]          busy,
   output logic [NUM_CH-1:0]          done
);

   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [DIV_W-1:0] DIV_ZERO_C = {DIV_W{1'b0}};
   localparam logic [DIV_W-1:0] DIV_ONE_C  = DIV_W'(1'b1);
   localparam logic [IDX_W-1:0] IDX_ZERO_C = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0] IDX_ONE_C  = IDX_W'(1'b1);
   localparam logic [IDX_W-1:0] IDX_LAST_C = IDX_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SYNC   = 3'd1,
      ST_START  = 3'd2,
      ST_DATA   = 3'd3,
`ifdef LASER_TX_PARITY_EN
      ST_PARITY = 3'd4,
`endif
      ST_STOP   = 3'd5
   } state_t;

`ifdef LASER_TX_PARITY_EN
   // Even parity: the transmitted bit makes the total count of ones even.
   function automatic logic even_parity(input logic [DATA_W-1:0] word);
      return ^word;
   endfunction
`endif

   // ---------------------------------------------------------------------
   // Shared bit-period tick generator
   // ---------------------------------------------------------------------
   logic [DIV_W-1:0] cnt_r;
   logic [DIV_W-1:0] per_r;
   logic [DIV_W-1:0] div_eff_s;
   logic [DIV_W-1:0] cur_per_s;
   logic             tick_s;

   // Period in force: divider is looked at only on the first cycle of a period
   // (counter at 0) and held in per_r for the rest of that period.
   always_comb begin
      div_eff_s = divider;
      cur_per_s = per_r;
      if (divider == DIV_ZERO_C) begin
         div_eff_s = DIV_ONE_C;
      end else begin
         div_eff_s = divider;
      end
      if (cnt_r == DIV_ZERO_C) begin
         cur_per_s = div_eff_s;
      end else begin
         cur_per_s = per_r;
      end
      tick_s = en && (cnt_r == (cur_per_s - DIV_ONE_C));
   end

   // Period counter: free-runs 0..P-1 while enabled, parked at 0 otherwise.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_r <= DIV_ZERO_C;
         per_r <= DIV_ONE_C;
      end else if (!en) begin
         cnt_r <= DIV_ZERO_C;
         per_r <= per_r;
      end else begin
         if (cnt_r == DIV_ZERO_C) begin
            per_r <= cur_per_s;
         end
         if (tick_s) begin
            cnt_r <= DIV_ZERO_C;
         end else begin
            cnt_r <= cnt_r + DIV_ONE_C;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Per-channel framing FSMs
   // ---------------------------------------------------------------------
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_t            state_r;
      state_t            nxt_state_s;
      logic [IDX_W-1:0]  idx_r;
      logic [IDX_W-1:0]  nxt_idx_s;
      logic [DATA_W-1:0] word_r;
      logic [DATA_W-1:0] nxt_word_s;
      logic              rdy_r;
      logic              busy_r;
      logic              done_r;
      logic [1:0]        laser_r;
      logic              nxt_rdy_s;
      logic              nxt_busy_s;
      logic              nxt_done_s;
      logic [1:0]        nxt_laser_s;
      logic              line_bit_s;

      // Next state plus the output values that go with it, so that every
      // output is a flop aligned with the state register.
      always_comb begin
         nxt_state_s = state_r;
         nxt_idx_s   = idx_r;
         nxt_word_s  = word_r;
         nxt_done_s  = 1'b0;
         nxt_laser_s = 2'b00;
         line_bit_s  = 1'b0;

         if (!en) begin
            // Abort: drop the frame and the latched word, no done pulse.
            nxt_state_s = ST_IDLE;
            nxt_idx_s   = IDX_ZERO_C;
            nxt_word_s  = {DATA_W{1'b0}};
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (data_valid[gi] && rdy_r) begin
                     nxt_state_s = ST_SYNC;
                     nxt_word_s  = data_in[gi*DATA_W +: DATA_W];
                  end else begin
                     nxt_state_s = ST_IDLE;
                  end
               end
               ST_SYNC: begin
                  if (tick_s) begin
                     nxt_state_s = ST_START;
                  end else begin
                     nxt_state_s = ST_SYNC;
                  end
               end
               ST_START: begin
                  if (tick_s) begin
                     nxt_state_s = ST_DATA;
                     nxt_idx_s   = IDX_LAST_C;
                  end else begin
                     nxt_state_s = ST_START;
                  end
               end
               ST_DATA: begin
                  if (tick_s && (idx_r == IDX_ZERO_C)) begin
`ifdef LASER_TX_PARITY_EN
                     nxt_state_s = ST_PARITY;
`else
                     nxt_state_s = ST_STOP;
`endif
                  end else if (tick_s) begin
                     nxt_idx_s = idx_r - IDX_ONE_C;
                  end else begin
                     nxt_state_s = ST_DATA;
                  end
               end
`ifdef LASER_TX_PARITY_EN
               ST_PARITY: begin
                  if (tick_s) begin
                     nxt_state_s = ST_STOP;
                  end else begin
                     nxt_state_s = ST_PARITY;
                  end
               end
`endif
               ST_STOP: begin
                  if (tick_s) begin
                     nxt_state_s = ST_IDLE;
                     nxt_done_s  = 1'b1;
                  end else begin
                     nxt_state_s = ST_STOP;
                  end
               end
               default: begin
                  nxt_state_s = ST_IDLE;
               end
            endcase
         end

         case (nxt_state_s)
            ST_START: line_bit_s = 1'b1;
            ST_DATA:  line_bit_s = nxt_word_s[nxt_idx_s];
`ifdef LASER_TX_PARITY_EN
            ST_PARITY: line_bit_s = even_parity(nxt_word_s);
`endif
            ST_STOP:  line_bit_s = 1'b0;
            default:  line_bit_s = 1'b0;
         endcase

         if ((nxt_state_s == ST_IDLE) || (nxt_state_s == ST_SYNC)) begin
            nxt_laser_s = 2'b00;
         end else begin
            nxt_laser_s = {line_bit_s, ~line_bit_s};
         end

         nxt_rdy_s  = en && (nxt_state_s == ST_IDLE);
         nxt_busy_s = (nxt_state_s != ST_IDLE);
      end

      // Channel state and registered outputs.
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            state_r <= ST_IDLE;
            idx_r   <= IDX_ZERO_C;
            word_r  <= {DATA_W{1'b0}};
            rdy_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            laser_r <= 2'b00;
         end else begin
            state_r <= nxt_state_s;
            idx_r   <= nxt_idx_s;
            word_r  <= nxt_word_s;
            rdy_r   <= nxt_rdy_s;
            busy_r  <= nxt_busy_s;
            done_r  <= nxt_done_s;
            laser_r <= nxt_laser_s;
         end
      end

      assign data_ready[gi]      = rdy_r;
      assign busy[gi]            = busy_r;
      assign done[gi]            = done_r;
      assign laser_out[2*gi +: 2] = laser_r;
   end

endmodule

// File: tb/tb_laser_multi_transmitter.sv
// -----------------------------------------------------------------------------
// tb_laser_multi_transmitter
//
// Self-checking bench for laser_multi_transmitter (NUM_CH=2, DATA_W=8).
// A vector table drives whole frames; the expected per-cycle laser pairs are
// pushed to per-channel queues when a word is sent and popped as the line is
// observed. Hand-written sequences cover reset, enable abort, a divider change
// mid-frame and reset asserted mid-frame.
// -----------------------------------------------------------------------------
module tb_laser_multi_transmitter;

   localparam int NUM_CH = 2;
   localparam int DATA_W = 8;
   localparam int DIV_W  = 8;

   logic                      clock = 1'b0;
   logic                      reset;
   logic                      en;
   logic [DIV_W-1:0]          divider;
   logic [NUM_CH*DATA_W-1:0]  data_in;
   logic [NUM_CH-1:0]         data_valid;
   logic [NUM_CH-1:0]         data_ready;
   logic [2*NUM_CH-1:0]       laser_out;
   logic [NUM_CH-1:0]         busy;
   logic [NUM_CH-1:0]         done;

   always #5 clock = ~clock;

   laser_multi_transmitter #(
      .NUM_CH (NUM_CH),
      .DATA_W (DATA_W),
      .DIV_W  (DIV_W)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .en         (en),
      .divider    (divider),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .laser_out  (laser_out),
      .busy       (busy),
      .done       (done)
   );

   typedef struct {
      logic [1:0] mask;
      logic [7:0] w0;
      logic [7:0] w1;
      logic [7:0] div;
   } vec_t;

   vec_t       vecs[6];
   int         n_cmp = 0;
   int         n_err = 0;
   logic [1:0] q0[$];
   logic [1:0] q1[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int per_of(input logic [7:0] d);
      return (d == 8'd0) ? 1 : int'(d);
   endfunction

   task automatic push_pair(input int ch, input logic [1:0] v);
      if (ch == 0) q0.push_back(v);
      else         q1.push_back(v);
   endtask

   // Expected line for one frame: START lasts p_start cycles, every later bit p.
   task automatic push_frame(input int ch, input logic [7:0] w, input int p_start, input int p);
      logic b;
      for (int k = 0; k < p_start; k++) push_pair(ch, 2'b10);
      for (int bi = 7; bi >= 0; bi--) begin
         b = w[bi];
         for (int k = 0; k < p; k++) push_pair(ch, {b, ~b});
      end
`ifdef LASER_TX_PARITY_EN
      b = ^w;
      for (int k = 0; k < p; k++) push_pair(ch, {b, ~b});
`endif
      for (int k = 0; k < p; k++) push_pair(ch, 2'b01);
   endtask

   task automatic wait_ready(input logic [1:0] mask);
      int cnt;
      cnt = 0;
      while (((data_ready & mask) != mask) && (cnt < 50)) begin
         @(negedge clock);
         cnt++;
      end
      check("ready_wait", {30'd0, data_ready & mask}, {30'd0, mask});
   endtask

   // Present words for one cycle; returns at the negedge after the accept edge.
   task automatic send(input logic [1:0] mask, input logic [7:0] w0, input logic [7:0] w1);
      data_in    = {w1, w0};
      data_valid = mask;
      @(negedge clock);
      data_valid = 2'b00;
      data_in    = 16'hDEAD;
      check("sync_busy", {30'd0, busy}, {30'd0, mask});
      check("sync_quiet", {28'd0, laser_out}, 32'd0);
   endtask

   // Step until START shows on the line; latency must be 1..p cycles.
   task automatic wait_start(input int p);
      int lat;
      lat = 0;
      while ((laser_out == 4'b0000) && (lat < p + 2)) begin
         @(negedge clock);
         lat++;
      end
      check("start_latency", {31'd0, (lat >= 1) && (lat <= p)}, 32'd1);
   endtask

   task automatic compare_stream(input logic [1:0] mask);
      logic [1:0] e0;
      logic [1:0] e1;
      while ((q0.size() > 0) || (q1.size() > 0)) begin
         e0 = (q0.size() > 0) ? q0.pop_front() : 2'b00;
         e1 = (q1.size() > 0) ? q1.pop_front() : 2'b00;
         check("line_stream", {26'd0, done, laser_out}, {26'd0, 2'b00, e1, e0});
         @(negedge clock);
      end
      check("done_pulse", {24'd0, done, laser_out, busy}, {24'd0, mask, 4'b0000, 2'b00});
      @(negedge clock);
      check("after_done", {28'd0, done, data_ready}, {28'd0, 2'b00, 2'b11});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      en         = 1'b1;
      divider    = 8'd4;
      data_in    = 16'h0000;
      data_valid = 2'b00;

      vecs[0] = '{2'b01, 8'hC8, 8'h00, 8'd4};
      vecs[1] = '{2'b11, 8'h12, 8'h34, 8'd4};
      vecs[2] = '{2'b10, 8'h00, 8'hA5, 8'd3};
      vecs[3] = '{2'b01, 8'hFF, 8'h00, 8'd0};
      vecs[4] = '{2'b01, 8'h01, 8'h00, 8'd1};
      vecs[5] = '{2'b11, 8'h5A, 8'hC3, 8'd2};

      // Reset values and first ready
      #23;
      check("reset_outs", {22'd0, laser_out, data_ready, busy, done}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      check("ready_before_edge", {30'd0, data_ready}, 32'd0);
      @(negedge clock);
      check("ready_after_reset", {30'd0, data_ready}, {30'd0, 2'b11});

      // Table-driven frames
      for (int v = 0; v < 6; v++) begin
         int p;
         divider = vecs[v].div;
         p = per_of(vecs[v].div);
         repeat (6) @(negedge clock);
         wait_ready(vecs[v].mask);
         if (vecs[v].mask[0]) push_frame(0, vecs[v].w0, p, p);
         if (vecs[v].mask[1]) push_frame(1, vecs[v].w1, p, p);
         send(vecs[v].mask, vecs[v].w0, vecs[v].w1);
         wait_start(p);
         compare_stream(vecs[v].mask);
      end

      // Enable dropped at bit 3 of a frame
      divider = 8'd4;
      repeat (6) @(negedge clock);
      wait_ready(2'b01);
      send(2'b01, 8'hB7, 8'h00);
      wait_start(4);
      repeat (20) @(negedge clock);
      check("mid_frame_busy", {30'd0, busy}, {30'd0, 2'b01});
      en = 1'b0;
      @(negedge clock);
      check("en_abort", {22'd0, laser_out, busy, done, data_ready}, 32'd0);
      for (int k = 0; k < 6; k++) begin
         check("abort_quiet", {26'd0, done, laser_out}, 32'd0);
         @(negedge clock);
      end
      en = 1'b1;
      @(negedge clock);
      check("ready_after_en", {30'd0, data_ready}, {30'd0, 2'b11});

      // Divider 4 -> 2 during the START bit
      divider = 8'd4;
      repeat (6) @(negedge clock);
      wait_ready(2'b01);
      push_frame(0, 8'hC8, 4, 2);
      send(2'b01, 8'hC8, 8'h00);
      wait_start(4);
      check("divchg_first", {30'd0, laser_out[1:0]}, {30'd0, q0.pop_front()});
      @(negedge clock);
      divider = 8'd2;
      compare_stream(2'b01);

      // Reset asserted mid-DATA
      divider = 8'd2;
      repeat (6) @(negedge clock);
      wait_ready(2'b01);
      send(2'b01, 8'h96, 8'h00);
      wait_start(2);
      repeat (5) @(negedge clock);
      check("pre_reset_busy", {30'd0, busy}, {30'd0, 2'b01});
      #2 reset = 1'b1;
      #1;
      check("async_reset", {22'd0, laser_out, data_ready, busy, done}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("ready_after_rst", {26'd0, data_ready, laser_out}, {26'd0, 2'b11, 4'b0000});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
